// File: rtl/ddr3_burst_writer.sv
// ddr3_burst_writer
//   Packs a stream of IN_W-bit words into AVL_W-bit beats (little-endian,
//   word k in bits [k*IN_W +: IN_W]), buffers the beats in a FIFO and writes
//   them to a DDR3 Avalon-MM port as bursts of BURST_LEN beats. A flush ends
//   the session: any partial beat is zero-padded and all buffered beats are
//   written out as bursts of min(count, BURST_LEN), then done pulses.
//
//   Optional feature macro: DDR3_WR_BYTEEN_EN adds ddr3_avl_be, all ones for
//   full beats and ones only over the filled words of a flushed partial beat.
//
// Ports
//   ddr3_clk, reset_n           clock, asynchronous active-low reset
//   start, start_addr, flush    session control (start only honoured in IDLE)
//   in_valid/in_ready/in_data   word stream
//   busy, done                  session active / one-cycle end-of-session pulse
//   ddr3_avl_*                  Avalon burst write master
module ddr3_burst_writer #(
  parameter int IN_W       = 32,
  parameter int AVL_W      = 128,
  parameter int ADDR_W     = 26,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              ddr3_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              busy,
  output logic              done,
  input  logic              ddr3_avl_ready,
  output logic              ddr3_avl_burstbegin,
  output logic              ddr3_avl_write_req,
  output logic [ADDR_W-1:0] ddr3_avl_addr,
  output logic [AVL_W-1:0]  ddr3_avl_wr_data,
  output logic [6:0]        ddr3_avl_size
`ifdef DDR3_WR_BYTEEN_EN
  ,
  output logic [AVL_W/8-1:0] ddr3_avl_be
`endif
);
  localparam int WPB = AVL_W / IN_W;
  localparam int PCW = $clog2(WPB + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [PCW-1:0] WPB_C    = PCW'(WPB);
  localparam logic [PW-1:0]  PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  BL_C     = CW'(BURST_LEN);
  localparam logic [6:0]     BL_SZ    = 7'(BURST_LEN);
`ifdef DDR3_WR_BYTEEN_EN
  localparam int BPW = IN_W / 8;
  localparam int BEW = AVL_W / 8;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [AVL_W-1:0]  pack_data_q, pack_data_d;
  logic [PCW-1:0]    pack_cnt_q, pack_cnt_d;
  logic              pend_vld_q, pend_vld_d;   // completed beat waiting one cycle to enter the FIFO
  logic [AVL_W-1:0]  pend_data_q, pend_data_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              act_q, act_d;             // burst in progress
  logic              wreq_q, wreq_d, bb_q, bb_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr_q, next_addr_d;
  logic [AVL_W-1:0]  wdata_q, wdata_d;
  logic [6:0]        size_q, size_d, left_q, left_d;
  logic [AVL_W-1:0]  mem [FIFO_DEPTH];

  logic              accept, push, pop, start_ok;
  logic [AVL_W-1:0]  pk_data;
  logic [PCW-1:0]    pk_cnt;
  logic [6:0]        burst_sz;
`ifdef DDR3_WR_BYTEEN_EN
  logic [BEW-1:0]    pend_be_q, pend_be_d, be_q, be_d, pk_be;
  logic [BEW-1:0]    be_mem [FIFO_DEPTH];
`endif

  assign in_ready = (state_q == RUN) && (cnt_q != DEPTH_C) && !pend_vld_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    pack_data_d = pack_data_q;
    pack_cnt_d  = pack_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    act_d       = act_q;
    wreq_d      = wreq_q;
    bb_d        = bb_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    left_d      = left_q;
    done        = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    accept      = in_valid & in_ready;
    pk_data     = pack_data_q;
    pk_cnt      = pack_cnt_q;
`ifdef DDR3_WR_BYTEEN_EN
    pend_be_d   = pend_be_q;
    be_d        = be_q;
    pk_be       = '0;
`endif

    // top-level session control
    case (state_q)
      IDLE:  if (start) begin
               state_d     = RUN;
               next_addr_d = start_addr;
             end
      RUN:   if (flush) state_d = DRAIN;
      DRAIN: if (!act_q && !pend_vld_q && cnt_q == '0) begin
               state_d = IDLE;
               done    = 1'b1;
             end
      default: state_d = IDLE;
    endcase

    if (pend_vld_q) begin
      push       = 1'b1;
      pend_vld_d = 1'b0;
    end

    // packer; in_ready is low while a beat is pending, so a fresh pending
    // beat never collides with the one being pushed this cycle
    if (accept) begin
      for (int k = 0; k < WPB; k++)
        if (pack_cnt_q == PCW'(k)) pk_data[k*IN_W +: IN_W] = in_data;
      pk_cnt = pack_cnt_q + PCW'(1);
    end
`ifdef DDR3_WR_BYTEEN_EN
    for (int b = 0; b < BEW; b++) pk_be[b] = (PCW'(b / BPW) < pk_cnt);
`endif
    if (pk_cnt == WPB_C || (state_q == RUN && flush && pk_cnt != '0)) begin
      // unfilled words of a flushed beat are already zero: the pack
      // register is cleared every time a beat leaves it
      pend_vld_d  = 1'b1;
      pend_data_d = pk_data;
      pack_data_d = '0;
      pack_cnt_d  = '0;
`ifdef DDR3_WR_BYTEEN_EN
      pend_be_d   = pk_be;
`endif
    end else begin
      pack_data_d = pk_data;
      pack_cnt_d  = pk_cnt;
    end

    // burst engine: beats separated by one idle cycle of write_req
    burst_sz = (cnt_q >= BL_C) ? BL_SZ : 7'(cnt_q);
    start_ok = !act_q && ((state_q == RUN && cnt_q >= BL_C) ||
                          (state_q == DRAIN && !pend_vld_q && cnt_q != '0));
    if (wreq_q && ddr3_avl_ready) begin
      pop    = 1'b1;
      wreq_d = 1'b0;
      bb_d   = 1'b0;
      left_d = left_q - 7'd1;
      if (left_q == 7'd1) act_d = 1'b0;
    end else if (act_q && !wreq_q) begin
      wreq_d  = 1'b1;
      wdata_d = mem[rd_ptr_q];
`ifdef DDR3_WR_BYTEEN_EN
      be_d    = be_mem[rd_ptr_q];
`endif
    end else if (start_ok) begin
      act_d       = 1'b1;
      wreq_d      = 1'b1;
      bb_d        = 1'b1;
      addr_d      = next_addr_q;
      next_addr_d = next_addr_q + ADDR_W'(burst_sz);
      size_d      = burst_sz;
      left_d      = burst_sz;
      wdata_d     = mem[rd_ptr_q];
`ifdef DDR3_WR_BYTEEN_EN
      be_d        = be_mem[rd_ptr_q];
`endif
    end

    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pack_data_q <= '0;
      pack_cnt_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      act_q       <= 1'b0;
      wreq_q      <= 1'b0;
      bb_q        <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      left_q      <= '0;
`ifdef DDR3_WR_BYTEEN_EN
      pend_be_q   <= '0;
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pack_data_q <= pack_data_d;
      pack_cnt_q  <= pack_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      wreq_q      <= wreq_d;
      bb_q        <= bb_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      left_q      <= left_d;
`ifdef DDR3_WR_BYTEEN_EN
      pend_be_q   <= pend_be_d;
      be_q        <= be_d;
`endif
    end
  end

  // beat storage needs no reset: only entries counted by cnt_q are read
  always_ff @(posedge ddr3_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= pend_data_q;
`ifdef DDR3_WR_BYTEEN_EN
      be_mem[wr_ptr_q] <= pend_be_q;
`endif
    end
  end

  assign ddr3_avl_burstbegin = bb_q;
  assign ddr3_avl_write_req  = wreq_q;
  assign ddr3_avl_addr       = addr_q;
  assign ddr3_avl_wr_data    = wdata_q;
  assign ddr3_avl_size       = size_q;
`ifdef DDR3_WR_BYTEEN_EN
  assign ddr3_avl_be         = be_q;
`endif

endmodule

// File: tb/tb_ddr3_burst_writer.sv
// Self-checking bench for ddr3_burst_writer with default parameters.
// A beat-level model (queue of expected beats, burst sizes from queue depth,
// running burst address) is compared against the Avalon outputs every cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_ddr3_burst_writer;
  localparam int IN_W = 32, AVL_W = 128, ADDR_W = 26, BL = 4, WPB = 4;

  logic              ddr3_clk = 1'b0, reset_n = 1'b0;
  logic              start = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic              ddr3_avl_ready = 1'b1;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_ready, busy, done, bb, wreq;
  logic [ADDR_W-1:0] addr;
  logic [AVL_W-1:0]  wdata;
  logic [6:0]        size;
`ifdef DDR3_WR_BYTEEN_EN
  logic [15:0]       be;
`endif

  int checks = 0, errors = 0;

  always #5 ddr3_clk = ~ddr3_clk;

  ddr3_burst_writer dut (
    .ddr3_clk(ddr3_clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .ddr3_avl_ready(ddr3_avl_ready),
    .ddr3_avl_burstbegin(bb), .ddr3_avl_write_req(wreq), .ddr3_avl_addr(addr),
    .ddr3_avl_wr_data(wdata), .ddr3_avl_size(size)
`ifdef DDR3_WR_BYTEEN_EN
    , .ddr3_avl_be(be)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [AVL_W-1:0]  exp_q[$];
  int                exp_nw[$];
  logic [AVL_W-1:0]  mbeat = '0;
  int                mcnt = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  function automatic void model_word(input logic [IN_W-1:0] w);
    mbeat[mcnt*IN_W +: IN_W] = w;
    mcnt++;
    if (mcnt == WPB) begin
      exp_q.push_back(mbeat);
      exp_nw.push_back(WPB);
      mbeat = '0;
      mcnt  = 0;
    end
  endfunction

  function automatic void model_flush();
    if (mcnt != 0) begin
      exp_q.push_back(mbeat);
      exp_nw.push_back(mcnt);
      mbeat = '0;
      mcnt  = 0;
    end
  endfunction

  function automatic logic [15:0] be_for(input int nw);
    logic [15:0] v = '0;
    for (int b = 0; b < 16; b++) v[b] = ((b / 4) < nw);
    return v;
  endfunction

  // ---------------- ready driver + per-cycle compare ----------------
  int  rmode = 0;          // 0: ready high, 1: stall 3 cycles on burst first beat, 2: ready low
  int  bidx = 0, cur_size = 0, stall_cnt = 0, stall_cycles = 0;
  bit  gap_exp = 1'b0;
  bit  r;
  logic [ADDR_W-1:0] cap_baddr[$];
  int                cap_bsize[$];
  logic [AVL_W-1:0]  cap_data[$];
  logic [15:0]       cap_be[$];

  initial forever begin
    @(negedge ddr3_clk);
    if (!reset_n) begin
      bidx = 0; gap_exp = 1'b0; stall_cnt = 0;
    end else begin
      r = 1'b1;
      if (rmode == 2) r = 1'b0;
      else if (rmode == 1 && wreq && bb && stall_cnt < 3) begin
        r = 1'b0; stall_cnt++; stall_cycles++;
      end
      ddr3_avl_ready = r;
      if (gap_exp) chk("gap_between_beats", wreq, 0);
      gap_exp = 1'b0;
      if (wreq) begin
        if (exp_q.size() == 0) chk("spurious_write_req", wreq, 0);
        else begin
          if (bidx == 0) cur_size = (exp_q.size() < BL) ? exp_q.size() : BL;
          chk("addr", addr, exp_addr);
          chk("size", size, cur_size);
          chk("wr_data", wdata, exp_q[0]);
          chk("burstbegin", bb, bidx == 0);
`ifdef DDR3_WR_BYTEEN_EN
          chk("be", be, be_for(exp_nw[0]));
`endif
          if (r) begin
            if (bidx == 0) begin
              cap_baddr.push_back(addr);
              cap_bsize.push_back(int'(size));
            end
            cap_data.push_back(wdata);
`ifdef DDR3_WR_BYTEEN_EN
            cap_be.push_back(be);
`endif
            void'(exp_q.pop_front());
            void'(exp_nw.pop_front());
            bidx++; stall_cnt = 0; gap_exp = 1'b1;
            if (bidx == cur_size) begin
              bidx = 0;
              exp_addr = exp_addr + ADDR_W'(cur_size);
            end
          end
        end
      end else if (bb) chk("burstbegin_without_write_req", bb, 0);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic clear_caps();
    cap_baddr.delete(); cap_bsize.delete(); cap_data.delete(); cap_be.delete();
    stall_cycles = 0;
  endtask

  task automatic session(input logic [ADDR_W-1:0] sa);
    start = 1'b1; start_addr = sa; exp_addr = sa;
    @(negedge ddr3_clk);
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input int base, input int budget, output int got);
    int i = 0, cyc = 0;
    while (i < n && cyc < budget) begin
      in_valid = 1'b1;
      in_data  = IN_W'(base + i);
      if (in_ready) begin
        model_word(IN_W'(base + i));
        i++;
      end
      @(negedge ddr3_clk);
      cyc++;
    end
    in_valid = 1'b0;
    got = i;
  endtask

  task automatic do_flush(input string tag, input bit quick);
    int n = 0;
    flush = 1'b1;
    model_flush();
    @(negedge ddr3_clk);
    flush = 1'b0;
    while (!done && n < 300) begin
      @(negedge ddr3_clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    if (quick) chk({tag, "_done_latency"}, n, 0);
    chk({tag, "_busy_at_done"}, busy, 1);
    @(negedge ddr3_clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_beats_outstanding"}, exp_q.size(), 0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int got;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_write_req", wreq, 0);
    chk("rst_burstbegin", bb, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wdata, 0);
    chk("rst_size", size, 0);
    @(negedge ddr3_clk); @(negedge ddr3_clk);
    reset_n = 1'b1;
    @(negedge ddr3_clk);

    // 16 words -> one burst of 4 at 0x100
    clear_caps(); rmode = 0;
    session(26'h100);
    send_words(16, 0, 200, got);
    chk("t1_accepted", got, 16);
    do_flush("t1", 1'b0);
    chk("t1_bursts", cap_baddr.size(), 1);
    chk("t1_addr", cap_baddr[0], 26'h100);
    chk("t1_size", cap_bsize[0], 4);
    chk("t1_beats", cap_data.size(), 4);
    chk("t1_beat0", cap_data[0], 128'h00000003_00000002_00000001_00000000);

    // 32 words, 3-cycle stall on each first beat -> bursts at 0x100, 0x104
    clear_caps(); rmode = 1;
    session(26'h100);
    send_words(32, 32'hA000, 400, got);
    chk("t2_accepted", got, 32);
    do_flush("t2", 1'b0);
    chk("t2_bursts", cap_baddr.size(), 2);
    chk("t2_addr0", cap_baddr[0], 26'h100);
    chk("t2_addr1", cap_baddr[1], 26'h104);
    chk("t2_beats", cap_data.size(), 8);
    chk("t2_stall_cycles", stall_cycles, 6);
    chk("t2_beat4", cap_data[4], 128'h0000A013_0000A012_0000A011_0000A010);
    rmode = 0;

    // six words then flush -> one burst of 2, zero-padded second beat
    clear_caps();
    session(26'h40);
    send_words(6, 0, 100, got);
    chk("t3_accepted", got, 6);
    do_flush("t3", 1'b0);
    chk("t3_bursts", cap_baddr.size(), 1);
    chk("t3_size", cap_bsize[0], 2);
    chk("t3_beat1", cap_data[1], 128'h00000000_00000000_00000005_00000004);
`ifdef DDR3_WR_BYTEEN_EN
    chk("t3_be0", cap_be[0], 16'hFFFF);
    chk("t3_be1", cap_be[1], 16'h00FF);
`endif

    // empty flush -> done next cycle, no Avalon traffic
    clear_caps();
    session(26'h200);
    do_flush("t4", 1'b1);
    chk("t4_no_traffic", cap_data.size(), 0);

    // address wrap
    clear_caps();
    session(26'h3FFFFFE);
    send_words(32, 0, 400, got);
    chk("t5_accepted", got, 32);
    do_flush("t5", 1'b0);
    chk("t5_bursts", cap_baddr.size(), 2);
    chk("t5_addr0", cap_baddr[0], 26'h3FFFFFE);
    chk("t5_addr1", cap_baddr[1], 26'h0000002);

    // ready held low: FIFO fills at 8 beats, then reset mid-burst
    clear_caps(); rmode = 2;
    session(26'h0);
    send_words(40, 1000, 100, got);
    chk("t6_accepted", got, 32);
    chk("t6_in_ready_full", in_ready, 0);
    chk("t6_write_req_stalled", wreq, 1);
    chk("t6_burstbegin_stalled", bb, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_write_req", wreq, 0);
    chk("t6_rst_burstbegin", bb, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_size", size, 0);
    exp_q.delete(); exp_nw.delete(); mbeat = '0; mcnt = 0;
    rmode = 0;
    @(negedge ddr3_clk);
    reset_n = 1'b1;
    @(negedge ddr3_clk);
    @(negedge ddr3_clk);
    chk("t6_idle_after_reset", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr3_burst_writer.md
DDR3_BURST_WRITER -- requirements
Module: ddr3_burst_writer

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 SHALL have parameter AVL_W, default 128, Avalon data width; AVL_W/IN_W = WPB (words per beat), a power of 2 ≥1.
REQ-003 SHALL have parameter ADDR_W, default 26, Avalon beat address width.
REQ-004 SHALL have parameter BURST_LEN, default 4, max beats per burst, a power of 2 from 1 to 64.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, beat FIFO depth, a power of 2 ≥ BURST_LEN.
REQ-006 SHALL have ports: ddr3_clk in 1, sole clock; reset_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: start in 1, begin session; start_addr in ADDR_W, first beat address; flush in 1, end session.
REQ-008 SHALL have ports: in_valid in 1; in_ready out 1; in_data in IN_W, word stream.
REQ-009 SHALL have ports: busy out 1, session active; done out 1, one-cycle pulse at session end.
REQ-010 SHALL have ports: ddr3_avl_ready in 1; ddr3_avl_burstbegin out 1; ddr3_avl_write_req out 1; ddr3_avl_addr out ADDR_W; ddr3_avl_wr_data out AVL_W; ddr3_avl_size out 7, beats in current burst.

Function
REQ-011 SHALL have top states IDLE, RUN, DRAIN; start in IDLE latches start_addr, goes RUN, sets busy; start outside IDLE is ignored.
REQ-012 SHALL assert in_ready only in RUN when the FIFO is not full and no beat is pending entry into it; a word transfers on in_valid & in_ready.
REQ-013 SHALL pack words little-endian: word k of a beat occupies bits [k*IN_W +: IN_W]; completed beat enters the FIFO the cycle after its last word.
REQ-014 SHALL, in RUN, start a burst the cycle after FIFO count ≥ BURST_LEN with no burst active, size = BURST_LEN.
REQ-015 SHALL assert burstbegin together with write_req on the first beat of each burst only, held with it until ddr3_avl_ready.
REQ-016 SHALL hold write_req, wr_data, addr, size stable while ready is low; a beat is consumed on write_req & ready; next beat is driven the following cycle, with write_req low for one cycle between beats; FIFO pops on consumption.
REQ-017 SHALL present ddr3_avl_addr = burst start address for the whole burst; next burst address = previous + size, modulo 2^ADDR_W (wrap, no error).
REQ-018 SHALL, on flush in RUN, go DRAIN; a word accepted in the same cycle as flush is included; a partial beat is zero-padded and pushed.
REQ-019 SHALL, in DRAIN, issue remaining FIFO beats as bursts of min(count, BURST_LEN); after the last beat is consumed, pulse done, drop busy, return IDLE.
REQ-020 SHALL, on flush with nothing buffered and no partial beat, pulse done the next cycle with no Avalon traffic.
REQ-021 SHALL never assert write_req outside an active burst, nor start a burst while one is active.

Reset
REQ-022 SHALL, on reset_n low, immediately set state IDLE, FIFO empty, pack count 0, and outputs burstbegin, write_req, busy, done, in_ready to 0, addr, wr_data, size to 0; reset mid-burst abandons it.

Configuration
REQ-023 SHALL, with DDR3_WR_BYTEEN_EN defined, add output ddr3_avl_be (AVL_W/8), all ones for full beats and ones only over filled words for a flushed partial beat; without it, no be port and padded words write zeros.

Verification
REQ-024 Defaults, start_addr=0x100, 16 words 0..15 -> one burst, addr 0x100, size 4, beat0 data {3,2,1,0}, burstbegin on beat0 only.
REQ-025 32 words, ready low 3 cycles on each first beat -> two bursts at 0x100 and 0x104, signals held stable while stalled, no beat lost.
REQ-026 Six words then flush -> one burst, size 2, beat1 = {0,0,5,4}; with DDR3_WR_BYTEEN_EN, be = 0x00FF on beat1; done then busy low.
REQ-027 start_addr=0x3FFFFFE, 32 words -> second burst addr wraps to 0x0000002.
REQ-028 ready held low, 40 words offered -> in_ready drops at FIFO full (8 beats plus pack); reset_n low mid-burst -> write_req, burstbegin 0 the same cycle.
